fc_neuron_bank: RTL

Parametrised fixed-point multiply-accumulate bank for the fully-connected layer. It holds NUM_NEURONS signed accumulators. Each accepted beat adds one input × weight product into the accumulator chosen by `in_addr`. When the vector ends, the bank drains every neuron result, saturated to DATA_WIDTH, over a valid/ready output stream. It sits between the AXI-fed input/weight buffers and the activation/output stage of the FC IP.

---
 rtl/fc_neuron_bank.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/fc_neuron_bank.sv
// Fixed-point MAC bank: one product per beat into a per-neuron accumulator, then a saturated drain.
// Optional build macro FC_RELU_EN clamps drained results at zero.
module fc_neuron_bank #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned FRACTIONAL  = 5,
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned ADDR_WIDTH  = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
    parameter int unsigned ACC_GUARD   = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data,
    input  logic signed [DATA_WIDTH-1:0] weight,
    input  logic        [ADDR_WIDTH-1:0] in_addr,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic        [DATA_WIDTH-1:0] out_data,
    output logic        [ADDR_WIDTH-1:0] out_addr,
    output logic                         out_last,
    output logic                         busy,
    output logic                         sat_flag
);

    localparam int unsigned ACC_W  = DATA_WIDTH + ACC_GUARD;
    localparam int unsigned PROD_W = 2 * DATA_WIDTH;
    localparam int unsigned SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_NEURONS - 1);

    typedef enum logic [1:0] {StIdle, StAccum, StFlush, StDrain} state_e;

    state_e state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic                  sat_q, sat_d;

    logic signed [PROD_W-1:0] full_prod;
    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic [ADDR_WIDTH-1:0]    paddr_q, paddr_d;
    logic                     pvalid_q, pvalid_d;

    logic signed [ACC_W-1:0] acc_q [NUM_NEURONS];
    logic signed [ACC_W-1:0] acc_d [NUM_NEURONS];

    logic signed [ACC_W-1:0]  acc_rd;
    logic signed [SUM_W-1:0]  sum;
    logic [SUM_W-ACC_W:0]     sum_hi;
    logic                     acc_ovf;
    logic signed [ACC_W-1:0]  acc_new;

    logic signed [ACC_W-1:0]  acc_sel;
    logic [ACC_GUARD:0]       sel_hi;
    logic                     out_ovf;
    logic [DATA_WIDTH-1:0]    out_sat;
    logic [DATA_WIDTH-1:0]    out_val;
    logic                     draining;
    logic                     start_ok;

    assign draining = (state_q == StDrain);
    assign start_ok = (state_q == StIdle) && start;

    // Stage 1: full-precision product, arithmetic shift truncates toward -inf.
    assign full_prod = PROD_W'(in_data) * PROD_W'(weight);

    always_comb begin
        pvalid_d = (state_q == StAccum) && in_valid && (32'(in_addr) < NUM_NEURONS);
        prod_d   = full_prod >>> FRACTIONAL;
        paddr_d  = in_addr;
    end

    // Stage 2: single-cycle read-modify-write, so back-to-back hits on one neuron chain correctly.
    always_comb begin
        acc_rd  = acc_q[paddr_q];
        sum     = SUM_W'(acc_rd) + SUM_W'(prod_q);
        sum_hi  = sum[SUM_W-1:ACC_W-1];
        acc_ovf = ~((&sum_hi) | ~(|sum_hi));
        if (acc_ovf) begin
            acc_new = sum[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end else begin
            acc_new = sum[ACC_W-1:0];
        end
    end

    always_comb begin
        acc_d = acc_q;
        if (start_ok) begin
            for (int i = 0; i < int'(NUM_NEURONS); i++) begin
                acc_d[i] = '0;
            end
        end else if (pvalid_q) begin
            acc_d[paddr_q] = acc_new;
        end
    end

    // Drain path: saturate the selected accumulator down to DATA_WIDTH.
    always_comb begin
        acc_sel = acc_q[idx_q];
        sel_hi  = acc_sel[ACC_W-1:DATA_WIDTH-1];
        out_ovf = ~((&sel_hi) | ~(|sel_hi));
        if (out_ovf) begin
            out_sat = acc_sel[ACC_W-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                       : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            out_sat = acc_sel[DATA_WIDTH-1:0];
        end
`ifdef FC_RELU_EN
        out_val = out_sat[DATA_WIDTH-1] ? '0 : out_sat;
`else
        out_val = out_sat;
`endif
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StAccum;
                end
            end
            StAccum: begin
                if (in_valid && in_last) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                state_d = StDrain;
                idx_d   = '0;
            end
            StDrain: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = StIdle;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + ADDR_WIDTH'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        if (start_ok) begin
            sat_d = 1'b0;
        end else begin
            sat_d = sat_q | (pvalid_q & acc_ovf) | (draining & out_ovf);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            idx_q    <= '0;
            sat_q    <= 1'b0;
            prod_q   <= '0;
            paddr_q  <= '0;
            pvalid_q <= 1'b0;
            for (int i = 0; i < int'(NUM_NEURONS); i++) begin
                acc_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            sat_q    <= sat_d;
            prod_q   <= prod_d;
            paddr_q  <= paddr_d;
            pvalid_q <= pvalid_d;
            for (int i = 0; i < int'(NUM_NEURONS); i++) begin
                acc_q[i] <= acc_d[i];
            end
        end
    end

    // Outputs come straight from registered state; nothing combinational from out_ready.
    assign in_ready  = (state_q == StAccum);
    assign busy      = (state_q != StIdle);
    assign sat_flag  = sat_q;
    assign out_valid = draining;
    assign out_data  = draining ? out_val : '0;
    assign out_addr  = draining ? idx_q : '0;
    assign out_last  = draining && (idx_q == LAST_IDX);

endmodule
